// File: rtl/mem_bus_ctrl.sv
// CPU native-bus bridge to program ROM, 1-cycle-latency data RAM and a GPIO output register.
// Optional define BUS_ERR_EN adds sticky bus_err / bus_err_addr and a 0xDEAD_BEEF unmapped read value.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for mem_valid; decode, ROM/GPIO/unmapped serviced here
//   RAM_WAIT | RAM address was presented last cycle, capture ram_rdata
//   RESP     | mem_ready pulse, mem_rdata stable
module mem_bus_ctrl #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
    parameter logic [31:0] GPIO_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [3:0]  ram_wen,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [31:0] gpio_out
`ifdef BUS_ERR_EN
    ,
    output logic        bus_err,
    output logic [31:0] bus_err_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    // 33-bit bounds so a RAM window ending at 4 GiB cannot overflow the compare
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;
    localparam logic [32:0] RAM_LO    = {1'b0, RAM_BASE};
    localparam logic [32:0] RAM_HI    = RAM_LO + 33'(RAM_WORDS) * 33'd4;

`ifdef BUS_ERR_EN
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] UNMAPPED_DATA = 32'h0000_0000;
`endif

    state_t      state;
    state_t      state_nx;

    logic [32:0] addr_ext;
    logic        hit_rom;
    logic        hit_ram;
    logic        hit_gpio;
    logic        is_write;

    logic [3:0]  ram_wen_c;
    logic        rdata_ld;
    logic [31:0] rdata_nx;
    logic        gpio_ld;
`ifdef BUS_ERR_EN
    logic        err_set;
`endif

    // ---------------------------------------------------------------
    // Address decode, priority ROM > RAM > GPIO > unmapped
    // ---------------------------------------------------------------
    always_comb begin
        addr_ext = {1'b0, mem_addr};
        hit_rom  = (addr_ext < ROM_LIMIT);
        hit_ram  = !hit_rom && (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
        hit_gpio = !hit_rom && !hit_ram && (mem_addr[31:2] == GPIO_ADDR[31:2]);
        is_write = |mem_wstrb;
    end

    assign rom_addr  = mem_addr;
    assign ram_wdata = mem_wdata;
    assign ram_addr  = 22'((mem_addr - RAM_BASE) >> 2);

    // Reset gates the write enables directly so an abort cannot leak a write
    assign ram_wen   = rst ? 4'b0000 : ram_wen_c;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_ready = 1'b0;
        ram_wen_c = 4'b0000;
        rdata_ld  = 1'b0;
        rdata_nx  = mem_rdata;
        gpio_ld   = 1'b0;
`ifdef BUS_ERR_EN
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (hit_ram) begin
                        ram_wen_c = mem_wstrb;
                        state_nx  = RAM_WAIT;
                    end else begin
                        rdata_ld = 1'b1;
                        state_nx = RESP;
                        if (hit_rom) begin
                            rdata_nx = rom_data;
`ifdef BUS_ERR_EN
                            err_set  = is_write;
`endif
                        end else if (hit_gpio) begin
                            rdata_nx = gpio_out;
                            gpio_ld  = is_write;
                        end else begin
                            rdata_nx = UNMAPPED_DATA;
`ifdef BUS_ERR_EN
                            err_set  = 1'b1;
`endif
                        end
                    end
                end
            end
            RAM_WAIT: begin
                rdata_ld = 1'b1;
                rdata_nx = ram_rdata;
                state_nx = RESP;
            end
            RESP: begin
                mem_ready = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 32'h0000_0000;
        end else if (rdata_ld) begin
            mem_rdata <= rdata_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= 32'h0000_0000;
        end else if (gpio_ld) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    gpio_out[8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef BUS_ERR_EN
    // First error wins; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err      <= 1'b0;
            bus_err_addr <= 32'h0000_0000;
        end else if (err_set && !bus_err) begin
            bus_err      <= 1'b1;
            bus_err_addr <= mem_addr;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed cases plus randomized transactions against a
// word-level model of ROM/RAM/GPIO contents and per-region latency rules.
module tb_mem_bus_ctrl;

    localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
    localparam logic [31:0] GPIO_ADDR = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] gpio_out;
`ifdef BUS_ERR_EN
    logic        bus_err;
    logic [31:0] bus_err_addr;
`endif

    int compared   = 0;
    int mismatched = 0;

    mem_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .gpio_out  (gpio_out)
`ifdef BUS_ERR_EN
        ,
        .bus_err     (bus_err),
        .bus_err_addr(bus_err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a fixed pattern, word 2 holds the documented value
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a[31:2] == 30'd2) return 32'h1234_5678;
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
    endfunction
    assign rom_data = rom_fn(rom_addr);

    // RAM device: synchronous read-first, byte enables
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    int          wen_pulses = 0;
    logic [3:0]  last_wen;
    logic [21:0] last_wen_addr;
    always @(negedge clk) begin
        if (ram_wen != 4'b0000) begin
            wen_pulses++;
            last_wen      = ram_wen;
            last_wen_addr = ram_addr;
        end
    end

    // Reference model state
    logic [31:0] ref_ram [256];
    logic [31:0] ref_gpio;
    logic        ref_err;
    logic [31:0] ref_err_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        longint      al;
        bit          is_rom, is_ram, is_gpio;
        int          exp_lat, n, pulses0;
        bit          got, chk_rd;
        logic [31:0] exp_rd, rd, old;
        int          w;

        al      = longint'(a);
        is_rom  = al < 1024;
        is_ram  = !is_rom && al >= longint'(RAM_BASE) && al < longint'(RAM_BASE) + 1024;
        is_gpio = !is_rom && !is_ram && (a[31:2] == GPIO_ADDR[31:2]);
        exp_lat = is_ram ? 3 : 2;
        w       = int'((a - RAM_BASE) >> 2) & 255;
        chk_rd  = 1'b1;
        exp_rd  = 32'h0;
        if (is_rom) exp_rd = rom_fn(a);
        else if (is_ram) exp_rd = ref_ram[w];
        else if (is_gpio) begin exp_rd = ref_gpio; chk_rd = (ws == 4'b0000); end
        else begin
`ifdef BUS_ERR_EN
            exp_rd = 32'hDEAD_BEEF;
`endif
            chk_rd = (ws == 4'b0000);
        end

        pulses0   = wen_pulses;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        n   = 0;
        got = 1'b0;
        rd  = 32'h0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_ready) begin got = 1'b1; rd = mem_rdata; end
        end
        check("latency", n, exp_lat);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        if (!got) return;

        if (chk_rd) check("rdata", rd, exp_rd);
        if (is_ram) begin
            old = ref_ram[w];
            for (int b = 0; b < 4; b++)
                if (ws[b]) old[8*b +: 8] = wd[8*b +: 8];
            ref_ram[w] = old;
        end
        if (is_gpio)
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_gpio[8*b +: 8] = wd[8*b +: 8];
        if (!is_ram && !is_gpio && (!is_rom || ws != 4'b0000) && !ref_err) begin
            ref_err      = 1'b1;
            ref_err_addr = a;
        end

        check("wen_pulses", wen_pulses - pulses0, (is_ram && ws != 4'b0000) ? 1 : 0);
        if (is_ram && ws != 4'b0000) begin
            check("wen_value", {28'h0, last_wen}, {28'h0, ws});
            check("wen_addr", {10'h0, last_wen_addr}, 32'((a - RAM_BASE) >> 2));
        end
        check("gpio_out", gpio_out, ref_gpio);
`ifdef BUS_ERR_EN
        check("bus_err", {31'h0, bus_err}, {31'h0, ref_err});
        check("bus_err_addr", bus_err_addr, ref_err_addr);
`endif
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("ready_idle", {31'h0, mem_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [3:0]  ws;
        logic [31:0] unmapped [5];

        unmapped[0] = 32'h0000_0400;
        unmapped[1] = 32'h0001_0400;
        unmapped[2] = 32'h2000_0000;
        unmapped[3] = 32'hFFFF_FFFC;
        unmapped[4] = 32'h0000_FFFC;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            ref_ram[i] = v;
        end
        ref_gpio     = 32'h0;
        ref_err      = 1'b0;
        ref_err_addr = 32'h0;

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_wen", {28'h0, ram_wen}, 32'h0);
`ifdef BUS_ERR_EN
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Documented cases
        txn(32'h0000_0008, 32'h0, 4'b0000);
        txn(32'h0001_0010, 32'hAABB_CCDD, 4'b0011);
        txn(32'h0001_0010, 32'h0, 4'b0000);
        txn(GPIO_ADDR, 32'h0000_00A5, 4'b0001);
        txn(GPIO_ADDR, 32'h0, 4'b0000);
        check("gpio_a5", gpio_out, 32'h0000_00A5);
        txn(32'h0000_0400, 32'h0, 4'b0000);
        txn(32'h2000_0000, 32'h0, 4'b0000);
        // Boundaries
        txn(32'h0000_03FC, 32'h0, 4'b0000);
        txn(32'h0001_03FC, 32'h1122_3344, 4'b1111);
        txn(32'h0001_03FC, 32'h0, 4'b0000);
        txn(32'h0001_0400, 32'h0, 4'b0000);
        txn(32'h0001_0000, 32'h5566_7788, 4'b1000);
        txn(32'h0001_0000, 32'h0, 4'b0000);
        txn(32'h0000_0010, 32'hFFFF_FFFF, 4'b1111);
        txn(32'h0000_0010, 32'h0, 4'b0000);
        idle_cycles(1);

        // Reset in RAM_WAIT
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0020;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wen", {28'h0, ram_wen}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_ready", {31'h0, mem_ready}, 32'h0);
            check("rst_mid_gpio", gpio_out, 32'h0);
        end
        mem_addr  = 32'h0001_0024;
        mem_wdata = 32'hCAFE_F00D;
        mem_wstrb = 4'b1111;
        #1;
        check("rst_hold_wen", {28'h0, ram_wen}, 32'h0);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ref_gpio     = 32'h0;
        ref_err      = 1'b0;
        ref_err_addr = 32'h0;
        idle_cycles(1);
        txn(32'h0000_0008, 32'h0, 4'b0000);
        txn(32'h0001_0024, 32'h0, 4'b0000);

        // Randomized, back-to-back with occasional gaps
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
                1, 4:    a = RAM_BASE + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
                2:       a = GPIO_ADDR + 32'($urandom_range(0, 3));
                default: a = unmapped[$urandom_range(0, 4)];
            endcase
            ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            txn(a, $urandom, ws);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
